// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg: shared FSM states, frame width and limit defaults for the SPI motor command receiver
package motor_cmd_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  localparam int FRAME_BITS = 16;
  localparam logic [6:0] LIMIT_MAX_DEF = 7'd100;
  function automatic logic [6:0] sat_limit(input logic [6:0] v, input logic [6:0] m);
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: two-flop synchronizer plus one history flop for rise/fall detection
module spi_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or posedge reset)
    if (reset) s <= {3{INIT}};
    else s <= {s[1:0], d};
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_motor_cmd_rx.sv
// spi_motor_cmd_rx: receives 16-bit SPI motor frames, commits saturated limits, fails safe on watchdog expiry
module spi_motor_cmd_rx
  import motor_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 600000,
  parameter logic [6:0] LIMIT_MAX = LIMIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic       motor1_sign,
  output logic [6:0] motor1_upperlimit,
  output logic       motor2_sign,
  output logic [6:0] motor2_upperlimit,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       timeout
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] FULL = 5'(FRAME_BITS);
  localparam logic [4:0] OVER = 5'(FRAME_BITS + 1);
  logic sck_rise, sdi_s, cs_rise, cs_fall;
  logic sck_q_unused, sck_fall_unused, sdi_rise_unused, sdi_fall_unused, cs_q_unused;
  spi_sync #(.INIT(1'b0)) u_sck (.clk(clk), .reset(reset), .d(sck), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall_unused));
  spi_sync #(.INIT(1'b0)) u_sdi (.clk(clk), .reset(reset), .d(sdi), .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused));
  spi_sync #(.INIT(1'b1)) u_cs (.clk(clk), .reset(reset), .d(cs_n), .q(cs_q_unused), .rise(cs_rise), .fall(cs_fall));
  state_t state, state_n;
  logic [FRAME_BITS-1:0] sr;
  logic [4:0] cnt;
  logic [6:0] lim1, lim2;
  logic [WW-1:0] wd;
  logic clr, shift, commit, reject;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // a cs_n fall seen while checking starts the next frame directly so it is never lost
  always_comb begin
    state_n = state;
    clr = 1'b0;
    shift = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    unique case (state)
      IDLE: begin
        clr = cs_fall;
        state_n = cs_fall ? RECV : IDLE;
      end
      RECV: begin
        shift = sck_rise;
        state_n = cs_rise ? CHECK : RECV;
      end
      CHECK: begin
        commit = cnt == FULL;
        reject = cnt != FULL;
        clr = cs_fall;
        state_n = cs_fall ? RECV : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      motor1_sign <= 1'b0;
      motor2_sign <= 1'b0;
      lim1 <= '0;
      lim2 <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      wd <= '0;
    end else begin
      cmd_valid <= commit;
      frame_err <= reject;
      if (clr) begin
        sr <= '0;
        cnt <= '0;
      end else if (shift) begin
        sr <= {sr[FRAME_BITS-2:0], sdi_s};
        cnt <= cnt == OVER ? cnt : cnt + 5'd1;
      end
      if (commit) begin
        motor1_sign <= sr[15];
        lim1 <= sat_limit(sr[14:8], LIMIT_MAX);
        motor2_sign <= sr[7];
        lim2 <= sat_limit(sr[6:0], LIMIT_MAX);
      end
      wd <= commit ? '0 : (timeout ? wd : wd + 1'b1);
    end
  assign timeout = wd == WW'(TIMEOUT_CYCLES);
  assign motor1_upperlimit = timeout ? '0 : lim1;
  assign motor2_upperlimit = timeout ? '0 : lim2;
endmodule

// File: tb/tb_spi_motor_cmd_rx.sv
// tb_spi_motor_cmd_rx: directed frames with hand-computed expectations on a default and a short-watchdog instance
module tb_spi_motor_cmd_rx;
  logic clk = 1'b0, reset, sck, sdi, cs_n;
  logic m1s, m2s, cv, fe, to;
  logic [6:0] m1l, m2l;
  logic m1s_t, m2s_t, cv_t, fe_t, to_t;
  logic [6:0] m1l_t, m2l_t;
  int errors = 0, checks = 0;
  int nv = 0, ne = 0;
  int bv, be;
  bit found;
  always #5 clk = ~clk;
  spi_motor_cmd_rx dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .motor1_sign(m1s), .motor1_upperlimit(m1l), .motor2_sign(m2s), .motor2_upperlimit(m2l),
    .cmd_valid(cv), .frame_err(fe), .timeout(to)
  );
  spi_motor_cmd_rx #(.TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
    .motor1_sign(m1s_t), .motor1_upperlimit(m1l_t), .motor2_sign(m2s_t), .motor2_upperlimit(m2l_t),
    .cmd_valid(cv_t), .frame_err(fe_t), .timeout(to_t)
  );
  always @(negedge clk) begin
    nv += int'(cv);
    ne += int'(fe);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic start();
    @(posedge clk); #2 cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask
  task automatic shift_bits(input logic [31:0] d, input int n, input bit coinc);
    for (int i = 0; i < n; i++) begin
      sdi = d[n-1-i];
      repeat (2) @(posedge clk);
      #2 sck = 1'b1;
      if (coinc && i == n - 1) cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #2 sck = 1'b0;
    end
  endtask
  task automatic send(input logic [31:0] d, input int n, input bit coinc);
    start();
    shift_bits(d, n, coinc);
    if (!coinc) begin
      repeat (2) @(posedge clk);
      #2 cs_n = 1'b1;
    end
    repeat (3) @(posedge clk);
  endtask
  task automatic settle();
    repeat (15) @(negedge clk);
  endtask
  task automatic wait_cv_t();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = cv_t;
    end
    chk("wd_cmd_valid_seen", 32'(found), 32'd1);
  endtask
  task automatic expect_out(input string tag, input logic s1, input logic [6:0] l1, input logic s2, input logic [6:0] l2);
    chk({tag, "_m1s"}, 32'(m1s), 32'(s1));
    chk({tag, "_m1l"}, 32'(m1l), 32'(l1));
    chk({tag, "_m2s"}, 32'(m2s), 32'(s2));
    chk({tag, "_m2l"}, 32'(m2l), 32'(l2));
  endtask
  initial begin
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_out("rst", 1'b0, 7'd0, 1'b0, 7'd0);
    chk("rst_cv", 32'(cv), 32'd0);
    chk("rst_fe", 32'(fe), 32'd0);
    chk("rst_to", 32'(to_t), 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    bv = nv; be = ne;
    send(32'h999E, 16, 1'b0); settle();
    expect_out("f999e", 1'b1, 7'd25, 1'b1, 7'd30);
    chk("f999e_cv", 32'(nv - bv), 32'd1);
    chk("f999e_fe", 32'(ne - be), 32'd0);
    bv = nv; be = ne;
    send(32'hFF64, 16, 1'b0); settle();
    expect_out("fff64", 1'b1, 7'd100, 1'b0, 7'd100);
    chk("fff64_cv", 32'(nv - bv), 32'd1);
    bv = nv; be = ne;
    send(32'h1AB, 9, 1'b0); settle();
    chk("short_fe", 32'(ne - be), 32'd1);
    chk("short_cv", 32'(nv - bv), 32'd0);
    expect_out("short", 1'b1, 7'd100, 1'b0, 7'd100);
    bv = nv; be = ne;
    send(32'h1_0000, 17, 1'b0); settle();
    chk("long_fe", 32'(ne - be), 32'd1);
    chk("long_cv", 32'(nv - bv), 32'd0);
    expect_out("long", 1'b1, 7'd100, 1'b0, 7'd100);
    bv = nv; be = ne;
    send(32'h999E, 16, 1'b1); settle();
    chk("coinc_cv", 32'(nv - bv), 32'd1);
    chk("coinc_fe", 32'(ne - be), 32'd0);
    expect_out("coinc", 1'b1, 7'd25, 1'b1, 7'd30);
    bv = nv; be = ne;
    start();
    shift_bits(32'h99, 8, 1'b0);
    reset = 1'b1; cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    settle();
    expect_out("midrst", 1'b0, 7'd0, 1'b0, 7'd0);
    chk("midrst_fe", 32'(ne - be), 32'd0);
    chk("midrst_cv", 32'(nv - bv), 32'd0);
    bv = nv; be = ne;
    send(32'h1932, 16, 1'b0); settle();
    expect_out("f1932", 1'b0, 7'd25, 1'b0, 7'd50);
    chk("f1932_cv", 32'(nv - bv), 32'd1);
    send(32'h999E, 16, 1'b0);
    wait_cv_t();
    chk("wd_fresh_to", 32'(to_t), 32'd0);
    repeat (49) @(negedge clk);
    chk("wd_49_to", 32'(to_t), 32'd0);
    @(negedge clk);
    chk("wd_50_to", 32'(to_t), 32'd1);
    chk("wd_50_m1l", 32'(m1l_t), 32'd0);
    chk("wd_50_m2l", 32'(m2l_t), 32'd0);
    chk("wd_50_m1s", 32'(m1s_t), 32'd1);
    chk("wd_50_m2s", 32'(m2s_t), 32'd1);
    chk("wd_default_to", 32'(to), 32'd0);
    chk("wd_default_m1l", 32'(m1l), 32'd25);
    send(32'hFF64, 16, 1'b0);
    wait_cv_t();
    chk("wd_new_to", 32'(to_t), 32'd0);
    chk("wd_new_m1l", 32'(m1l_t), 32'd100);
    chk("wd_new_m2s", 32'(m2s_t), 32'd0);
    chk("wd_new_m2l", 32'(m2l_t), 32'd100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_motor_cmd_rx.md
SPI_MOTOR_CMD_RX -- requirements
Module: spi_motor_cmd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 600000: clk cycles without a valid frame before outputs fail safe (100 ms at 6 MHz).
REQ-002 SHALL have parameter LIMIT_MAX, default 7'd100: saturation ceiling for duty limits.
REQ-003 SHALL have port clk, input, 1: the single system clock; all state is on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sck, input, 1: SPI clock from the MCU, asynchronous to clk, mode 0.
REQ-006 SHALL have port sdi, input, 1: SPI data from the MCU, MSB first.
REQ-007 SHALL have port cs_n, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port motor1_sign, output, 1: direction for motor 1.
REQ-009 SHALL have port motor1_upperlimit, output, 7: duty limit for motor 1.
REQ-010 SHALL have port motor2_sign, output, 1: direction for motor 2.
REQ-011 SHALL have port motor2_upperlimit, output, 7: duty limit for motor 2.
REQ-012 SHALL have port cmd_valid, output, 1: one-clk pulse when a frame is committed.
REQ-013 SHALL have port frame_err, output, 1: one-clk pulse when a frame is rejected.
REQ-014 SHALL have port timeout, output, 1: level; high while the watchdog has expired.

Function
REQ-015 SHALL pass sck, sdi and cs_n through two-flop synchronizers; sck-rise, cs_n-fall and cs_n-rise SHALL be detected from the synchronized values; clk SHALL be at least 4x the sck frequency.
REQ-016 SHALL define a frame as 16 bits: bit15 = motor1_sign, bits14:8 = motor1 limit, bit7 = motor2_sign, bits6:0 = motor2 limit.
REQ-017 SHALL use FSM states IDLE, RECV and CHECK.
REQ-018 IDLE: on cs_n-fall, SHALL clear the shift register and the 5-bit bit counter and go to RECV.
REQ-019 RECV: on each sck-rise, SHALL shift in sdi at the LSB and increment the counter; the counter SHALL saturate at 17.
REQ-020 RECV: on cs_n-rise, SHALL go to CHECK; if sck-rise and cs_n-rise occur in the same clk, the bit SHALL be shifted in first.
REQ-021 CHECK, counter == 16: SHALL update all four motor outputs on the next clk edge, pulse cmd_valid in that same cycle, and return to IDLE.
REQ-022 CHECK, counter != 16 (short or overlong frame): SHALL hold the motor outputs, pulse frame_err, and return to IDLE.
REQ-023 On commit, each received limit greater than LIMIT_MAX SHALL be stored as LIMIT_MAX; other values SHALL be stored unchanged; sign bits SHALL be stored unchanged.
REQ-024 The watchdog counter SHALL clear on every cmd_valid and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-025 When the watchdog reaches TIMEOUT_CYCLES: timeout SHALL go to 1, both limits SHALL be forced to 0, and both signs SHALL hold their values.
REQ-026 timeout SHALL clear in the same cycle as the next cmd_valid, and that frame's values SHALL be applied.
REQ-027 sck edges while in IDLE or CHECK SHALL be ignored; a cs_n-fall while in CHECK SHALL be honored on the return to IDLE, no later than 1 clk after.

Reset
REQ-028 While reset is high, SHALL hold: FSM = IDLE; all counters = 0; shift register = 0; motor1_sign = motor2_sign = 0; both limits = 0; cmd_valid = frame_err = 0; timeout = 0; synchronizer flops = 1 (cs_n idle high) or 0 (sck, sdi).
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse; after release, reception SHALL restart only on a new cs_n-fall.

Structure
REQ-030 SHALL place the FSM state enum, FRAME_BITS = 16 and the default LIMIT_MAX in package motor_cmd_pkg.
REQ-031 SHALL implement the 2-flop synchronizer with rise/fall detection as sub-module spi_sync, instantiated once per SPI input.

Verification
REQ-032 Reset, then frame 0x999E -> motor1_sign = 1, motor1_upperlimit = 25, motor2_sign = 1, motor2_upperlimit = 30, one cmd_valid pulse.
REQ-033 Frame 0xFF64 -> motor1_upperlimit = 100 (saturated from 127), motor2_sign = 0, motor2_upperlimit = 100.
REQ-034 cs_n raised after 9 bits -> frame_err pulse, outputs unchanged from the prior frame; then 17 bits -> frame_err, outputs unchanged.
REQ-035 TIMEOUT_CYCLES = 50, valid frame, then idle 50 clk -> timeout = 1, both limits = 0, signs held; next valid frame -> timeout = 0, new values applied.
REQ-036 Reset pulsed after 8 bits of a frame -> all outputs 0, no frame_err; next full frame 0x1932 -> limits 25 and 50, signs 0.
REQ-037 Final sck-rise coincident with cs_n-rise on bit 16 -> frame accepted, cmd_valid pulses exactly once.
